ahb_arbiter: RTL

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ahb_arbiter.sv
// Round-robin AHB-Lite bus arbiter with fixed-length burst and locked-sequence
// grant freezing; also tracks the address- and data-phase owners for bus muxes.
module ahb_arbiter #(
    parameter int NUM_M = 3
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [NUM_M-1:0] HBUSREQ,
    input  logic [NUM_M-1:0] HLOCK,
    input  logic [1:0]       HTRANS,
    input  logic [2:0]       HBURST,
    input  logic             HREADY,
    output logic [NUM_M-1:0] HGRANT,
    output logic [1:0]       HMASTER,
    output logic [1:0]       HMASTER_D,
    output logic             HMASTLOCK
);

    typedef enum logic [1:0] {ARB, BURST, LOCKED} state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BR_INCR   = 3'b001;

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d, winner;
    logic [3:0]       cnt_q, cnt_d;
    logic             arb_en;
    logic [3:0]       req_x, lock_x;
    logic [NUM_M-1:0] gnt_oh;

    // Widen to 4 so a 2-bit index is always in range regardless of NUM_M.
    assign req_x  = 4'(HBUSREQ);
    assign lock_x = 4'(HLOCK);

    // Search starts one past the current owner; k == NUM_M revisits the owner
    // so a sole requester keeps the bus.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner = 2'd0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_M; k++) begin
            idx = 2'((int'(gnt_q) + k) % NUM_M);
            if (!found && req_x[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        arb_en  = 1'b0;
        if (HREADY) begin
            unique case (state_q)
                ARB: begin
                    if (HTRANS == TR_NONSEQ && HBURST[2:1] != 2'b00) begin
                        // Lock wins over burst entry; either way the grant freezes.
                        if (lock_x[gnt_q]) begin
                            state_d = LOCKED;
                        end else begin
                            state_d = BURST;
                            unique case (HBURST[2:1])
                                2'b01:   cnt_d = 4'd3;
                                2'b10:   cnt_d = 4'd7;
                                default: cnt_d = 4'd15;
                            endcase
                        end
                    end else if (HTRANS == TR_IDLE ||
                                 (HTRANS == TR_NONSEQ && HBURST != BR_INCR)) begin
                        arb_en = 1'b1;
                    end
                end
                BURST: begin
                    if (HTRANS == TR_SEQ) begin
                        if (cnt_q == 4'd1) begin
                            arb_en = 1'b1;
                            cnt_d  = 4'd0;
                        end else if (cnt_q != 4'd0) begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end else if (HTRANS != TR_BUSY) begin
                        arb_en = 1'b1;
                        cnt_d  = 4'd0;
                    end
                end
                LOCKED: begin
                    if (!lock_x[gnt_q] && (HTRANS == TR_IDLE || HTRANS == TR_NONSEQ))
                        arb_en = 1'b1;
                end
                default: state_d = ARB;
            endcase
            if (arb_en) begin
                gnt_d   = winner;
                state_d = lock_x[winner] ? LOCKED : ARB;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_M; i++)
            gnt_oh[i] = (gnt_d == 2'(i));
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= ARB;
            cnt_q     <= 4'd0;
            gnt_q     <= 2'd0;
            HGRANT    <= NUM_M'(1);
            HMASTER   <= 2'd0;
            HMASTER_D <= 2'd0;
            HMASTLOCK <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            HGRANT  <= gnt_oh;
            if (HREADY) begin
                HMASTER   <= gnt_q;
                HMASTER_D <= HMASTER;
                HMASTLOCK <= lock_x[gnt_q];
            end
        end
    end

endmodule
